// File: rtl/scarv_soc_bram_adapter.sv
// Request/response bridge from the SoC memory bus to a single-cycle BRAM port.
// Optional: define SCARV_SOC_BRAM_RANGE_CHECK_EN to reject accesses outside the window.
module scarv_soc_bram_adapter #(
    parameter logic [31:0] BASE     = 32'h0000_0000,
    parameter int unsigned SIZE     = 16384,
    parameter int unsigned WRITE_EN = 1,
    localparam int unsigned AW      = $clog2(SIZE)
) (
    input  logic          g_clk,
    input  logic          g_reset,
    input  logic          mem_req,
    output logic          mem_gnt,
    input  logic          mem_wen,
    input  logic [3:0]    mem_strb,
    input  logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_addr,
    output logic          mem_recv,
    input  logic          mem_ack,
    output logic          mem_error,
    output logic [31:0]   mem_rdata,
    output logic          bram_cen,
    output logic          bram_wen,
    output logic [3:0]    bram_strb,
    output logic [31:0]   bram_wdata,
    output logic [AW-1:0] bram_addr,
    input  logic [31:0]   bram_rdata
);

    logic [31:0] offset;
    logic        range_err;
    logic        req_err;
    logic        accept;
    logic [2:0]  occ;

    // One in-flight slot covers the BRAM read latency.
    logic        inf_valid_q, inf_valid_d;
    logic        inf_wen_q, inf_wen_d;
    logic        inf_err_q, inf_err_d;

    logic [31:0] fifo_data_q [3];
    logic        fifo_err_q  [3];
    logic [1:0]  wr_ptr_q, wr_ptr_d;
    logic [1:0]  rd_ptr_q, rd_ptr_d;
    logic [1:0]  cnt_q, cnt_d;

    logic        push;
    logic        pop;
    logic [31:0] push_data;

    assign offset = mem_addr - BASE;

`ifdef SCARV_SOC_BRAM_RANGE_CHECK_EN
    assign range_err = (offset >= 32'(SIZE));
`else
    logic unused_offset_hi;
    assign unused_offset_hi = ^offset[31:AW];
    assign range_err        = 1'b0;
`endif

    assign req_err = ((WRITE_EN == 0) && mem_wen) || range_err;

    assign occ     = {1'b0, cnt_q} + {2'b00, inf_valid_q};
    assign mem_gnt = !g_reset && (occ < 3'd3);
    assign accept  = mem_req && mem_gnt;

    assign bram_cen   = accept && !req_err;
    assign bram_wen   = mem_wen;
    assign bram_strb  = mem_strb;
    assign bram_wdata = mem_wdata;
    assign bram_addr  = offset[AW-1:0];

    assign push      = inf_valid_q;
    assign push_data = (inf_wen_q || inf_err_q) ? 32'h0 : bram_rdata;

    assign mem_recv  = (cnt_q != 2'd0);
    assign pop       = mem_recv && mem_ack;
    assign mem_rdata = mem_recv ? fifo_data_q[rd_ptr_q] : 32'h0;
    assign mem_error = mem_recv ? fifo_err_q[rd_ptr_q]  : 1'b0;

    always_comb begin
        inf_valid_d = accept;
        inf_wen_d   = mem_wen;
        inf_err_d   = req_err;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        cnt_d       = cnt_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == 2'd2) ? 2'd0 : wr_ptr_q + 2'd1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == 2'd2) ? 2'd0 : rd_ptr_q + 2'd1;
        end
        if (push && !pop) begin
            cnt_d = cnt_q + 2'd1;
        end else if (pop && !push) begin
            cnt_d = cnt_q - 2'd1;
        end
    end

    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            inf_valid_q <= 1'b0;
            inf_wen_q   <= 1'b0;
            inf_err_q   <= 1'b0;
            wr_ptr_q    <= 2'd0;
            rd_ptr_q    <= 2'd0;
            cnt_q       <= 2'd0;
        end else begin
            inf_valid_q <= inf_valid_d;
            inf_wen_q   <= inf_wen_d;
            inf_err_q   <= inf_err_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
        end
    end

    // Storage needs no reset: the count gates what is visible.
    always_ff @(posedge g_clk) begin
        if (!g_reset && push) begin
            fifo_data_q[wr_ptr_q] <= push_data;
            fifo_err_q[wr_ptr_q]  <= inf_err_q;
        end
    end

endmodule
